// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between the I-cache refill path (read-only) and
// the D-cache refill/writeback path. Round-robin arbitration, registered memory
// commands, a one-cycle release handshake per requester and a sticky watchdog.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 28,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // I-side
  input  logic              i_read_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic [DATA_W-1:0] i_rdata_o,
  output logic              i_busywait_o,
  // D-side
  input  logic              d_read_i,
  input  logic              d_write_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_busywait_o,
  // Memory
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_busywait_i,
  // Watchdog
  output logic              timeout_o
);

  localparam int unsigned WdogW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StGntI,
    StGntD,
    StDoneI,
    StDoneD
  } state_e;

  state_e              state_q, state_d;
  logic                prefer_d_q, prefer_d_d;  // 1: D wins a tie
  logic                issued_q, issued_d;
  logic [WdogW-1:0]    wdog_q, wdog_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                timeout_q, timeout_d;

  logic d_req;
  logic grant_d;
  logic grant_i;
  logic in_gnt;
  logic complete;
  logic expire;

  assign d_req   = d_read_i | d_write_i;
  assign grant_d = d_req & (~i_read_i | prefer_d_q);
  assign grant_i = i_read_i & ~grant_d;
  assign in_gnt  = (state_q == StGntI) || (state_q == StGntD);
  // A low busywait on the first grant cycle is stale (command not yet seen).
  assign complete = in_gnt & issued_q & ~mem_busywait_i;
  // Last allowed grant cycle: the counter would reach TIMEOUT on this edge.
  assign expire   = in_gnt & ~complete & (wdog_q == WdogW'(TIMEOUT - 1));

  // Release each requester only during its own DONE cycle.
  assign i_busywait_o = i_read_i & (state_q != StDoneI);
  assign d_busywait_o = d_req & (state_q != StDoneD);

  assign mem_read_o  = mem_read_q;
  assign mem_write_o = mem_write_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign i_rdata_o   = i_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign timeout_o   = timeout_q;

  // Next-state, command registration and read-data capture.
  always_comb begin
    state_d     = state_q;
    prefer_d_d  = prefer_d_q;
    issued_d    = issued_q;
    wdog_d      = wdog_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    timeout_d   = timeout_q;

    unique case (state_q)
      StIdle: begin
        issued_d = 1'b0;
        wdog_d   = '0;
        if (grant_d) begin
          state_d     = StGntD;
          prefer_d_d  = 1'b0;
          mem_addr_d  = d_addr_i;
          // Read and write together is a write.
          mem_write_d = d_write_i;
          mem_read_d  = ~d_write_i;
          if (d_write_i) begin
            mem_wdata_d = d_wdata_i;
          end
        end else if (grant_i) begin
          state_d     = StGntI;
          prefer_d_d  = 1'b1;
          mem_addr_d  = i_addr_i;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
        end
      end

      StGntI, StGntD: begin
        issued_d = 1'b1;
        wdog_d   = wdog_q + WdogW'(1);
        if (complete) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (mem_read_q) begin
            if (state_q == StGntI) begin
              i_rdata_d = mem_rdata_i;
            end else begin
              d_rdata_d = mem_rdata_i;
            end
          end
          state_d = (state_q == StGntI) ? StDoneI : StDoneD;
        end else if (expire) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          timeout_d   = 1'b1;
          state_d     = (state_q == StGntI) ? StDoneI : StDoneD;
        end
      end

      StDoneI, StDoneD: begin
        state_d = StIdle;
        wdog_d  = '0;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset forces idle with commands dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      prefer_d_q  <= 1'b1;
      issued_q    <= 1'b0;
      wdog_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prefer_d_q  <= prefer_d_d;
      issued_q    <= issued_d;
      wdog_q      <= wdog_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      timeout_q   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester tasks push expectations,
// a memory responder emulates latency, and a negedge monitor checks grants,
// commands, returned data, release latency and the watchdog flag.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 28;
  localparam int unsigned DW = 128;
  localparam int unsigned TO = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          i_read_i = 1'b0;
  logic [AW-1:0] i_addr_i = '0;
  logic [DW-1:0] i_rdata_o;
  logic          i_busywait_o;
  logic          d_read_i = 1'b0;
  logic          d_write_i = 1'b0;
  logic [AW-1:0] d_addr_i = '0;
  logic [DW-1:0] d_wdata_i = '0;
  logic [DW-1:0] d_rdata_o;
  logic          d_busywait_o;
  logic          mem_read_o;
  logic          mem_write_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          mem_busywait_i = 1'b0;
  logic          timeout_o;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .i_read_i      (i_read_i),
    .i_addr_i      (i_addr_i),
    .i_rdata_o     (i_rdata_o),
    .i_busywait_o  (i_busywait_o),
    .d_read_i      (d_read_i),
    .d_write_i     (d_write_i),
    .d_addr_i      (d_addr_i),
    .d_wdata_i     (d_wdata_i),
    .d_rdata_o     (d_rdata_o),
    .d_busywait_o  (d_busywait_o),
    .mem_read_o    (mem_read_o),
    .mem_write_o   (mem_write_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rdata_i   (mem_rdata_i),
    .mem_busywait_i(mem_busywait_i),
    .timeout_o     (timeout_o)
  );

  typedef struct {
    bit            write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  txn_t          i_q[$];
  txn_t          d_q[$];
  logic [DW-1:0] mem[logic [AW-1:0]];
  logic [DW-1:0] ref_d[logic [AW-1:0]];
  logic [DW-1:0] last_i = '0;
  logic [DW-1:0] last_d = '0;
  bit            last_was_d = 1'b0;  // reset favours D
  bit            exp_timeout = 1'b0;

  // Memory behaviour knobs: fixed_n < 0 means random 1..6 busy cycles.
  int            fixed_n = 3;
  bit            stuck = 1'b0;
  int            cur_n = 0;
  int            cnt = 0;
  bit            cmd_prev = 1'b0;
  bit            rsp_cmd;
  bit            rsp_busy;

  // Initial memory image; also the reference for never-written addresses.
  function automatic logic [DW-1:0] image(input logic [AW-1:0] a);
    logic [31:0] h;
    if (a == 28'h000_0010) return {16{8'hA5}};
    h = (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    return {h, ~h, h ^ 32'h1111_2222, h + 32'd7};
  endfunction

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return image(a);
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    if (ref_d.exists(a)) return ref_d[a];
    return image(a);
  endfunction

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Memory responder: N busy cycles from the first command cycle, then done.
  always begin
    @(posedge clk_i);
    #1;
    if (!rst_ni) begin
      cmd_prev       = 1'b0;
      mem_busywait_i = 1'b0;
    end else begin
      rsp_cmd = mem_read_o | mem_write_o;
      if (rsp_cmd && !cmd_prev) begin
        cnt   = (fixed_n >= 0) ? fixed_n : int'($urandom_range(6, 1));
        cur_n = cnt;
      end
      rsp_busy = rsp_cmd && (stuck || cnt > 0);
      if (rsp_busy && cnt > 0) cnt--;
      if (rsp_cmd && !rsp_busy && mem_write_o) mem[mem_addr_o] = mem_wdata_o;
      if (rsp_cmd && !rsp_busy && mem_read_o) mem_rdata_i = mem_rd(mem_addr_o);
      else mem_rdata_i = {$urandom, $urandom, $urandom, $urandom};
      mem_busywait_i = rsp_busy;
      cmd_prev       = rsp_cmd;
    end
  end

  // Monitor / scoreboard.
  int   cyc = 0;
  int   start_cyc = 0;
  bit   prev_i_req = 1'b0;
  bit   prev_d_req = 1'b0;
  bit   mon_cmd_prev = 1'b0;
  bit   mcmd;
  bit   exp_d;
  int   exp_lat;
  txn_t mt;
  logic [DW-1:0] exp_data;

  always @(negedge clk_i) begin
    cyc++;
    if (!rst_ni) begin
      mon_cmd_prev = 1'b0;
      prev_i_req   = 1'b0;
      prev_d_req   = 1'b0;
    end else begin
      mcmd = mem_read_o | mem_write_o;
      if (!i_read_i) check("i_busy_no_req", DW'(i_busywait_o), DW'(0));
      if (!(d_read_i | d_write_i)) check("d_busy_no_req", DW'(d_busywait_o), DW'(0));
      if (mcmd && !mon_cmd_prev) begin
        check("grant_has_requester", DW'(prev_i_req | prev_d_req), DW'(1));
        exp_d      = (prev_i_req && prev_d_req) ? !last_was_d : prev_d_req;
        last_was_d = exp_d;
        start_cyc  = cyc;
        if (exp_d) begin
          check("d_queue_nonempty_at_grant", DW'(d_q.size() > 0), DW'(1));
          if (d_q.size() > 0) begin
            mt = d_q[0];
            check("d_cmd_addr", DW'(mem_addr_o), DW'(mt.addr));
            check("d_cmd_write", DW'(mem_write_o), DW'(mt.write));
            check("d_cmd_read", DW'(mem_read_o), DW'(!mt.write));
            if (mt.write) check("d_cmd_wdata", mem_wdata_o, mt.wdata);
          end
        end else begin
          check("i_queue_nonempty_at_grant", DW'(i_q.size() > 0), DW'(1));
          if (i_q.size() > 0) begin
            mt = i_q[0];
            check("i_cmd_addr", DW'(mem_addr_o), DW'(mt.addr));
            check("i_cmd_read", DW'(mem_read_o), DW'(1));
            check("i_cmd_write", DW'(mem_write_o), DW'(0));
          end
        end
      end
      exp_lat = stuck ? int'(TO) : ((cur_n < 1 ? 1 : cur_n) + 1);
      if ((d_read_i | d_write_i) && !d_busywait_o) begin
        check("d_release_expected", DW'(d_q.size() > 0), DW'(1));
        if (d_q.size() > 0) begin
          mt       = d_q.pop_front();
          exp_data = (mt.write || stuck) ? last_d : mt.rdata;
          check("d_rdata", d_rdata_o, exp_data);
          last_d = exp_data;
          check("d_latency", DW'(cyc - start_cyc), DW'(exp_lat));
          if (stuck) exp_timeout = 1'b1;
          check("timeout_flag", DW'(timeout_o), DW'(exp_timeout));
        end
      end
      if (i_read_i && !i_busywait_o) begin
        check("i_release_expected", DW'(i_q.size() > 0), DW'(1));
        if (i_q.size() > 0) begin
          mt       = i_q.pop_front();
          exp_data = stuck ? last_i : mt.rdata;
          check("i_rdata", i_rdata_o, exp_data);
          last_i = exp_data;
          check("i_latency", DW'(cyc - start_cyc), DW'(exp_lat));
          if (stuck) exp_timeout = 1'b1;
          check("timeout_flag", DW'(timeout_o), DW'(exp_timeout));
        end
      end
      mon_cmd_prev = mcmd;
      prev_i_req   = i_read_i;
      prev_d_req   = d_read_i | d_write_i;
    end
  end

  task automatic do_i_read(input logic [AW-1:0] a);
    txn_t t;
    bit   done;
    t.write = 1'b0;
    t.addr  = a;
    t.wdata = '0;
    t.rdata = image(a);
    i_q.push_back(t);
    i_addr_i = a;
    i_read_i = 1'b1;
    done     = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk_i);
      if (!i_busywait_o) done = 1'b1;
      // Once our command is out, the inputs are free to wander.
      else if (mem_read_o && mem_addr_o == a) i_addr_i = AW'($urandom);
    end
    check("i_release_within_bound", DW'(done), DW'(1));
    @(posedge clk_i);
    #2;
    i_read_i = 1'b0;
  endtask

  task automatic do_d_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input bit commit);
    txn_t t;
    bit   done;
    t.write = wr;
    t.addr  = a;
    t.wdata = wd;
    t.rdata = ref_rd(a);
    if (wr && commit) ref_d[a] = wd;
    d_q.push_back(t);
    d_addr_i  = a;
    d_wdata_i = wd;
    d_write_i = wr;
    d_read_i  = wr ? 1'($urandom_range(1, 0)) : 1'b1;
    done      = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk_i);
      if (!d_busywait_o) done = 1'b1;
      else if ((mem_read_o | mem_write_o) && mem_addr_o == a) begin
        d_addr_i  = AW'($urandom);
        d_wdata_i = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    check("d_release_within_bound", DW'(done), DW'(1));
    @(posedge clk_i);
    #2;
    d_read_i  = 1'b0;
    d_write_i = 1'b0;
  endtask

  task automatic gap(input int unsigned n);
    for (int k = 0; k < int'(n); k++) begin
      @(posedge clk_i);
      #2;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    txn_t rt;
    #1;
    check("rst_mem_read", DW'(mem_read_o), DW'(0));
    check("rst_mem_write", DW'(mem_write_o), DW'(0));
    check("rst_mem_addr", DW'(mem_addr_o), DW'(0));
    check("rst_mem_wdata", mem_wdata_o, DW'(0));
    check("rst_i_rdata", i_rdata_o, DW'(0));
    check("rst_d_rdata", d_rdata_o, DW'(0));
    check("rst_timeout", DW'(timeout_o), DW'(0));
    repeat (3) @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    gap(1);

    // Both sides rise together: D first, then I.
    fixed_n = 2;
    fork
      do_i_read(28'h800_0040);
      do_d_txn(1'b0, 28'h000_0005, '0, 1'b1);
    join
    gap(2);

    // Directed I read, 3 busy cycles; directed D write.
    fixed_n = 3;
    do_i_read(28'h000_0010);
    gap(1);
    do_d_txn(1'b1, 28'h000_00FF, {8{16'h1234}}, 1'b1);
    gap(1);
    do_d_txn(1'b0, 28'h000_00FF, '0, 1'b1);
    gap(1);

    // Memory never busy: completion must wait for the second grant cycle.
    fixed_n = 0;
    fork
      for (int k = 0; k < 6; k++) do_i_read({1'b1, 27'($urandom)});
      for (int k = 0; k < 6; k++) do_d_txn(1'($urandom), AW'($urandom_range(15, 0)),
                                           {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    join
    gap(2);

    // Reset pulse while a D write is granted.
    fixed_n = 5;
    rt.write = 1'b1;
    rt.addr  = 28'h000_0007;
    rt.wdata = {4{32'hDEAD_BEEF}};
    rt.rdata = '0;
    d_q.push_back(rt);
    d_addr_i  = rt.addr;
    d_wdata_i = rt.wdata;
    d_write_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    check("midrst_mem_write", DW'(mem_write_o), DW'(0));
    check("midrst_mem_read", DW'(mem_read_o), DW'(0));
    check("midrst_mem_addr", DW'(mem_addr_o), DW'(0));
    check("midrst_mem_wdata", mem_wdata_o, DW'(0));
    check("midrst_d_rdata", d_rdata_o, DW'(0));
    check("midrst_d_busy_held", DW'(d_busywait_o), DW'(1));
    d_write_i = 1'b0;
    void'(d_q.pop_front());
    last_i      = '0;
    last_d      = '0;
    last_was_d  = 1'b0;
    exp_timeout = 1'b0;
    @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    gap(1);
    do_d_txn(1'b0, 28'h000_00FF, '0, 1'b1);
    gap(1);

    // Random traffic, random latency, random gaps (including back-to-back).
    fixed_n = -1;
    fork
      for (int k = 0; k < 30; k++) begin
        gap($urandom_range(2, 0));
        do_i_read({1'b1, 27'($urandom)});
      end
      for (int k = 0; k < 30; k++) begin
        gap($urandom_range(2, 0));
        do_d_txn(1'($urandom), AW'($urandom_range(15, 0)),
                 {$urandom, $urandom, $urandom, $urandom}, 1'b1);
      end
    join
    gap(2);

    // Watchdog: memory never answers.
    stuck = 1'b1;
    do_d_txn(1'b1, 28'h000_0003, {4{32'hCAFE_F00D}}, 1'b0);
    stuck = 1'b0;
    gap(1);
    check("timeout_sticky", DW'(timeout_o), DW'(1));
    fixed_n = 2;
    do_i_read(28'h800_0123);
    do_d_txn(1'b0, 28'h000_0003, '0, 1'b1);
    gap(3);

    check("i_queue_drained", DW'(i_q.size()), DW'(0));
    check("d_queue_drained", DW'(d_q.size()), DW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
